reg_bank_cp: RTL and testbench
==============================

Name: reg_bank_cp

Overview:
- Parametrised, clocked successor to the single-bit enable/clear/preset latch cells.
- Holds N independent WIDTH-bit channels. Each channel has its own load enable, synchronous clear and synchronous preset.
- Each channel also has a sticky change flag, a clear/preset conflict flag, and a saturating update counter.
- Sits between control logic and datapath as a status/config register stage. A global freeze holds all loads.

Parameters:
- N, 4, number of channels
- WIDTH, 8, bits per channel
- RESET_VAL, '0, value loaded into every channel on rst
- PRESET_VAL, '1, value loaded on pre
- CNT_W, 4, width of each per-channel update counter

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- d  in  N*WIDTH  load data; channel i is d[i*WIDTH +: WIDTH]
- ena  in  N  per-channel load enable
- clr  in  N  per-channel synchronous clear (to 0)
- pre  in  N  per-channel synchronous preset (to PRESET_VAL)
- freeze  in  1  global load inhibit
- chg_ack  in  N  per-channel clear of chg
- q  out  N*WIDTH  channel values
- chg  out  N  sticky "q changed" flag
- conflict  out  N  one-cycle pulse: clr and pre asserted together
- upd_cnt  out  N*CNT_W  per-channel count of cycles in which q changed, saturating

Behaviour:
- Reset: asynchronous, active-high. While rst=1: q=RESET_VAL on all channels; chg=0, conflict=0, upd_cnt=0. Release is clocked normally; the first edge after release performs normal operation.
- Per-channel op is chosen each rising edge by fixed priority: CLR > PRE > LOAD > HOLD.
  - CLR when clr[i]=1: next q=0.
  - PRE when clr[i]=0 and pre[i]=1: next q=PRESET_VAL.
  - LOAD when clr[i]=0, pre[i]=0, ena[i]=1 and freeze=0: next q=d slice.
  - HOLD otherwise: q unchanged.
- Latency: one cycle. Inputs sampled at edge k appear on q after edge k.
- freeze blocks LOAD only. CLR and PRE still act while frozen.
- conflict[i]: registered, =1 for exactly the cycle after an edge that saw clr[i]=1 and pre[i]=1; otherwise 0. CLR wins (q=0).
- "Changed" means next q differs from current q. A load, clear or preset to the same value is not a change.
- chg[i]:
  - set on any edge where channel i changes;
  - cleared by chg_ack[i]=1 on an edge;
  - if set and ack occur on the same edge, set wins (chg stays 1).
- upd_cnt[i]: increments by 1 on every edge where channel i changes. Holds at 2^CNT_W-1 (no wrap). Cleared only by rst.
- Channels are fully independent: there is no cross-channel interaction except the shared freeze.
- All outputs are registered. No combinational path from inputs to outputs.

Decomposition:
- Package reg_bank_pkg: enum chan_op_t {OP_HOLD, OP_LOAD, OP_PRE, OP_CLR}, plus function chan_op_sel(clr, pre, ena, freeze) returning chan_op_t.
- Sub-module reg_chan: one channel containing q, chg, conflict and counter. It takes WIDTH, PRESET_VAL, RESET_VAL and CNT_W as parameters.
- reg_bank_cp is a generate loop of N reg_chan instances plus port slicing.

Test Plan:
- Reset and basic load (N=3, WIDTH=8):
  - Assert rst mid-cycle -> q=00/00/00, chg=000, upd_cnt=0 immediately, without waiting for an edge.
  - Release, then d ch0=0xA5, ena=001 for one edge -> next cycle q0=0xA5, chg=001, upd_cnt0=1. q1 and q2 unchanged.
- Priority: ch1 q=0x3C, clr=010 with pre=010 and ena=010 on the same edge -> q1=0x00, conflict=010 for exactly one cycle then 000, chg[1]=1.
  - Next edge pre=010 only -> q1=0xFF.
- Freeze: freeze=1, ena=111, d=0x11 per channel -> q unchanged, chg unchanged.
  - Same freeze with pre=100 -> q2=0xFF.
  - freeze=0 -> loads take effect next edge.
- No-change and ack race:
  - Load 0x5A into ch0 twice; ack chg between the loads -> second load leaves chg[0]=0 and upd_cnt0 unchanged.
  - Then load 0x5B with chg_ack[0]=1 on the same edge -> chg[0]=1.
- Counter saturation (CNT_W=4): toggle ch2 between 0x00 and 0x01 for 20 edges -> upd_cnt2 reaches 15 and stays at 15.
  - Assert rst -> upd_cnt2 returns to 0 asynchronously.

Source files
------------

// File: rtl/reg_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_pkg
// Purpose  : Shared types and helpers for the reg_bank_cp register bank.
//            Defines the per-channel operation encoding and the fixed
//            priority selector CLR > PRE > LOAD > HOLD.
// Revision : 1.0 - initial release
// ============================================================================
package reg_bank_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_PRE  = 2'd2,
    OP_CLR  = 2'd3
  } chan_op_t;

  // Fixed-priority operation select for one channel. freeze only inhibits
  // LOAD; clear and preset still take effect while frozen.
  function automatic chan_op_t chan_op_sel(input logic clr,
                                           input logic pre,
                                           input logic ena,
                                           input logic freeze);
    chan_op_t op;
    if (clr)                op = OP_CLR;
    else if (pre)           op = OP_PRE;
    else if (ena && !freeze) op = OP_LOAD;
    else                    op = OP_HOLD;
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_chan.sv
`default_nettype none
// ============================================================================
// Module   : reg_chan
// Purpose  : One channel of the register bank: value register with
//            clear/preset/load, sticky change flag, clear+preset conflict
//            pulse and a saturating update counter.
// Ports    : clk, rst      - clock, asynchronous active-high reset
//            i_d           - load data
//            i_ena         - load enable
//            i_clr, i_pre  - synchronous clear / preset
//            i_freeze      - load inhibit
//            i_chg_ack     - clears the sticky change flag
//            o_q           - channel value
//            o_chg         - sticky "value changed" flag
//            o_conflict    - one-cycle pulse after clr and pre together
//            o_upd_cnt     - saturating count of changing edges
// Revision : 1.0 - initial release
// ============================================================================
module reg_chan
  import reg_bank_pkg::*;
#(
  parameter int             WIDTH      = 8,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0,
  parameter logic [WIDTH-1:0] PRESET_VAL = '1,
  parameter int             CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_ena,
  input  logic             i_clr,
  input  logic             i_pre,
  input  logic             i_freeze,
  input  logic             i_chg_ack,
  output logic [WIDTH-1:0] o_q,
  output logic             o_chg,
  output logic             o_conflict,
  output logic [CNT_W-1:0] o_upd_cnt
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  logic [WIDTH-1:0] r_q;
  logic             r_chg;
  logic             r_conflict;
  logic [CNT_W-1:0] r_cnt;

  chan_op_t         w_op;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_changed;

  assign w_op = chan_op_sel(i_clr, i_pre, i_ena, i_freeze);

  always_comb begin
    w_q_nxt = r_q;
    case (w_op)
      OP_CLR:  w_q_nxt = '0;
      OP_PRE:  w_q_nxt = PRESET_VAL;
      OP_LOAD: w_q_nxt = i_d;
      default: w_q_nxt = r_q;
    endcase
  end

  // Writing the value already held is not a change.
  assign w_changed = (w_q_nxt != r_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q        <= RESET_VAL;
      r_chg      <= 1'b0;
      r_conflict <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_q        <= w_q_nxt;
      r_conflict <= i_clr & i_pre;
      // A change on the same edge as an ack keeps the flag set.
      if (w_changed)
        r_chg <= 1'b1;
      else if (i_chg_ack)
        r_chg <= 1'b0;
      if (w_changed && (r_cnt != C_CNT_MAX))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_q        = r_q;
  assign o_chg      = r_chg;
  assign o_conflict = r_conflict;
  assign o_upd_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: rtl/reg_bank_cp.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_cp
// Purpose  : Bank of N independent WIDTH-bit registers with per-channel
//            load/clear/preset, change tracking and update counting. A global
//            freeze inhibits loads on all channels.
// Ports    : clk, rst  - clock, asynchronous active-high reset
//            d         - load data, channel i at d[i*WIDTH +: WIDTH]
//            ena       - per-channel load enable
//            clr, pre  - per-channel synchronous clear / preset
//            freeze    - global load inhibit
//            chg_ack   - per-channel clear of chg
//            q         - channel values
//            chg       - sticky change flags
//            conflict  - one-cycle clr+pre pulses
//            upd_cnt   - per-channel saturating update counts
// Revision : 1.0 - initial release
// ============================================================================
module reg_bank_cp
  import reg_bank_pkg::*;
#(
  parameter int               N          = 4,
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0,
  parameter logic [WIDTH-1:0] PRESET_VAL = '1,
  parameter int               CNT_W      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] d,
  input  logic [N-1:0]       ena,
  input  logic [N-1:0]       clr,
  input  logic [N-1:0]       pre,
  input  logic               freeze,
  input  logic [N-1:0]       chg_ack,
  output logic [N*WIDTH-1:0] q,
  output logic [N-1:0]       chg,
  output logic [N-1:0]       conflict,
  output logic [N*CNT_W-1:0] upd_cnt
);

  for (genvar gi = 0; gi < N; gi++) begin : g_chan
    reg_chan #(
      .WIDTH      (WIDTH),
      .RESET_VAL  (RESET_VAL),
      .PRESET_VAL (PRESET_VAL),
      .CNT_W      (CNT_W)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .i_d        (d[gi*WIDTH +: WIDTH]),
      .i_ena      (ena[gi]),
      .i_clr      (clr[gi]),
      .i_pre      (pre[gi]),
      .i_freeze   (freeze),
      .i_chg_ack  (chg_ack[gi]),
      .o_q        (q[gi*WIDTH +: WIDTH]),
      .o_chg      (chg[gi]),
      .o_conflict (conflict[gi]),
      .o_upd_cnt  (upd_cnt[gi*CNT_W +: CNT_W])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_cp.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_bank_cp
// Purpose  : Self-checking bench for reg_bank_cp with N=3, WIDTH=8, CNT_W=4.
//            Directed vector table, counter saturation and asynchronous reset
//            sequences, then randomized traffic against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_bank_cp;

  localparam int N = 3;
  localparam int W = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N*W-1:0] d;
  logic [N-1:0]  ena, clr, pre, chg_ack;
  logic          freeze;
  logic [N*W-1:0] q;
  logic [N-1:0]  chg, conflict;
  logic [N*CW-1:0] upd_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  reg_bank_cp #(
    .N(N), .WIDTH(W), .RESET_VAL(8'h00), .PRESET_VAL(8'hFF), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .d(d), .ena(ena), .clr(clr), .pre(pre),
    .freeze(freeze), .chg_ack(chg_ack), .q(q), .chg(chg),
    .conflict(conflict), .upd_cnt(upd_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [N*W-1:0]  d;
    logic [N-1:0]    ena, clr, pre, ack;
    logic            frz;
    logic [N*W-1:0]  eq;
    logic [N-1:0]    echg, econf;
    logic [N*CW-1:0] ecnt;
  } vec_t;

  vec_t tbl[14];

  // Reference model state
  logic [W-1:0] m_q[N];
  bit           m_chg[N];
  bit           m_conf[N];
  int           m_cnt[N];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_q[i] = '0; m_chg[i] = 0; m_conf[i] = 0; m_cnt[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < N; i++) begin
      logic [W-1:0] nq;
      if (clr[i])                  nq = 8'h00;
      else if (pre[i])             nq = 8'hFF;
      else if (ena[i] && !freeze)  nq = d[i*W +: W];
      else                         nq = m_q[i];
      m_conf[i] = clr[i] && pre[i];
      if (nq != m_q[i]) begin
        m_chg[i] = 1;
        if (m_cnt[i] < 15) m_cnt[i]++;
      end else if (chg_ack[i]) begin
        m_chg[i] = 0;
      end
      m_q[i] = nq;
    end
  endtask

  task automatic model_check(input int cyc);
    logic [N*W-1:0]  eq;
    logic [N-1:0]    ec, ef;
    logic [N*CW-1:0] en;
    for (int i = 0; i < N; i++) begin
      eq[i*W +: W]   = m_q[i];
      ec[i]          = m_chg[i];
      ef[i]          = m_conf[i];
      en[i*CW +: CW] = CW'(m_cnt[i]);
    end
    chk($sformatf("rand%0d q", cyc), 32'(q), 32'(eq));
    chk($sformatf("rand%0d chg", cyc), 32'(chg), 32'(ec));
    chk($sformatf("rand%0d conflict", cyc), 32'(conflict), 32'(ef));
    chk($sformatf("rand%0d upd_cnt", cyc), 32'(upd_cnt), 32'(en));
  endtask

  task automatic idle_inputs();
    d = '0; ena = '0; clr = '0; pre = '0; chg_ack = '0; freeze = 1'b0;
  endtask

  initial begin
    //          d            ena    clr    pre    ack    frz   eq           echg   econf  ecnt
    tbl[0]  = '{24'h0000A5, 3'b001, 3'b000, 3'b000, 3'b000, 1'b0, 24'h0000A5, 3'b001, 3'b000, 12'h001};
    tbl[1]  = '{24'h003C00, 3'b010, 3'b000, 3'b000, 3'b001, 1'b0, 24'h003CA5, 3'b010, 3'b000, 12'h011};
    tbl[2]  = '{24'h007700, 3'b010, 3'b010, 3'b010, 3'b000, 1'b0, 24'h0000A5, 3'b010, 3'b010, 12'h021};
    tbl[3]  = '{24'h000000, 3'b000, 3'b000, 3'b010, 3'b000, 1'b0, 24'h00FFA5, 3'b010, 3'b000, 12'h031};
    tbl[4]  = '{24'h000000, 3'b000, 3'b000, 3'b000, 3'b111, 1'b0, 24'h00FFA5, 3'b000, 3'b000, 12'h031};
    tbl[5]  = '{24'h111111, 3'b111, 3'b000, 3'b000, 3'b000, 1'b1, 24'h00FFA5, 3'b000, 3'b000, 12'h031};
    tbl[6]  = '{24'h111111, 3'b111, 3'b000, 3'b100, 3'b000, 1'b1, 24'hFFFFA5, 3'b100, 3'b000, 12'h131};
    tbl[7]  = '{24'h111111, 3'b111, 3'b000, 3'b000, 3'b000, 1'b0, 24'h111111, 3'b111, 3'b000, 12'h242};
    tbl[8]  = '{24'h00005A, 3'b001, 3'b000, 3'b000, 3'b111, 1'b0, 24'h11115A, 3'b001, 3'b000, 12'h243};
    tbl[9]  = '{24'h000000, 3'b000, 3'b000, 3'b000, 3'b001, 1'b0, 24'h11115A, 3'b000, 3'b000, 12'h243};
    tbl[10] = '{24'h00005A, 3'b001, 3'b000, 3'b000, 3'b000, 1'b0, 24'h11115A, 3'b000, 3'b000, 12'h243};
    tbl[11] = '{24'h00005B, 3'b001, 3'b000, 3'b000, 3'b001, 1'b0, 24'h11115B, 3'b001, 3'b000, 12'h244};
    tbl[12] = '{24'h000000, 3'b000, 3'b101, 3'b000, 3'b000, 1'b1, 24'h001100, 3'b101, 3'b000, 12'h345};
    tbl[13] = '{24'h000000, 3'b000, 3'b100, 3'b000, 3'b100, 1'b0, 24'h001100, 3'b001, 3'b000, 12'h345};

    rst = 1'b1;
    idle_inputs();
    #1;
    chk("reset q", 32'(q), 32'h0);
    chk("reset chg", 32'(chg), 32'h0);
    chk("reset conflict", 32'(conflict), 32'h0);
    chk("reset upd_cnt", 32'(upd_cnt), 32'h0);

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed vector table, one edge per entry.
    for (int v = 0; v < 14; v++) begin
      d = tbl[v].d; ena = tbl[v].ena; clr = tbl[v].clr;
      pre = tbl[v].pre; chg_ack = tbl[v].ack; freeze = tbl[v].frz;
      @(posedge clk); #1;
      chk($sformatf("vec%0d q", v), 32'(q), 32'(tbl[v].eq));
      chk($sformatf("vec%0d chg", v), 32'(chg), 32'(tbl[v].echg));
      chk($sformatf("vec%0d conflict", v), 32'(conflict), 32'(tbl[v].econf));
      chk($sformatf("vec%0d upd_cnt", v), 32'(upd_cnt), 32'(tbl[v].ecnt));
      @(negedge clk);
    end

    // Counter saturation: ch2 starts at 0x00 with count 3, toggle 20 times.
    idle_inputs();
    for (int k = 1; k <= 20; k++) begin
      ena = 3'b100;
      d = {((k % 2) == 1) ? 8'h01 : 8'h00, 16'h0000};
      @(posedge clk); #1;
      chk($sformatf("sat%0d q2", k), 32'(q[23:16]), ((k % 2) == 1) ? 32'h1 : 32'h0);
      chk($sformatf("sat%0d cnt2", k), 32'(upd_cnt[11:8]), (3 + k > 15) ? 32'd15 : 32'(3 + k));
      @(negedge clk);
    end
    idle_inputs();

    // Asynchronous reset asserted mid-cycle, checked before any edge.
    #2;
    rst = 1'b1;
    #1;
    chk("async q", 32'(q), 32'h0);
    chk("async chg", 32'(chg), 32'h0);
    chk("async conflict", 32'(conflict), 32'h0);
    chk("async upd_cnt", 32'(upd_cnt), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Randomized traffic against the reference model.
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        clr[i]     = ($urandom % 8) == 0;
        pre[i]     = ($urandom % 6) == 0;
        ena[i]     = ($urandom % 2) == 0;
        chg_ack[i] = ($urandom % 4) == 0;
        d[i*W +: W] = (($urandom % 3) == 0) ? 8'($urandom) : 8'($urandom % 4);
      end
      freeze = ($urandom % 5) == 0;
      @(posedge clk);
      model_edge();
      #1;
      model_check(c);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
